pdm_capture: RTL

//  Upstream neighbour of the audio output stage. Drives the on-board PDM microphone clock,

---
 rtl/pdm_capture.sv | 115 +++++++++++
 1 files changed

// File: rtl/pdm_capture.sv
// rtl/pdm_capture.sv - PDM mic clock generator, bit sampler and 16-bit word packer for DelayBuffer Port A
// LSB-first packing: the first sampled bit of each word lands in write_data[0].
module pdm_capture #(
  parameter int MEM_WIDTH  = 16,
  parameter int MEM_DEPTH  = 65536,
  parameter int ADDR_WIDTH = 16,
  parameter int MIC_DIV    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  mode_loop,
  input  logic                  pdm_in,
  output logic                  mic_clk,
  output logic                  mic_lrsel,
  output logic [MEM_WIDTH-1:0]  write_data,
  output logic [ADDR_WIDTH-1:0] write_address,
  output logic                  write_enable,
  output logic                  busy,
  output logic                  done
);

  localparam int DIV_W = (MIC_DIV > 2) ? $clog2(MIC_DIV) : 1;
  localparam int BW    = $clog2(MEM_WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DONE} state_t;

  state_t                  state;
  state_t                  state_next;
  logic [DIV_W-1:0]        div_cnt;
  logic [DIV_W-1:0]        div_next;
  logic                    tick;
  logic [BW-1:0]           bit_index;
  logic [MEM_WIDTH-1:0]    shreg;
  logic [MEM_WIDTH-1:0]    shreg_next;
  logic                    capture;
  logic                    start_capture;

  assign tick     = (div_cnt == DIV_W'(MIC_DIV - 1));
  assign div_next = tick ? '0 : div_cnt + DIV_W'(1);

  // A stop in CAPTURE also suppresses that cycle's sample, so a word cut short never writes.
  assign capture       = (state == S_CAPTURE) && tick && !stop;
  assign start_capture = (state != S_CAPTURE) && (state_next == S_CAPTURE);

  assign busy      = (state == S_CAPTURE);
  assign done      = (state == S_DONE);
  assign mic_lrsel = 1'b0;

  always_comb begin
    shreg_next            = shreg;
    shreg_next[bit_index] = pdm_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (start && !stop) state_next = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (stop) begin
          state_next = S_IDLE;
        end else if (write_enable && !mode_loop &&
                     write_address == ADDR_WIDTH'(MEM_DEPTH - 1)) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (start) state_next = S_CAPTURE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt       <= '0;
      mic_clk       <= 1'b0;
      bit_index     <= '0;
      shreg         <= '0;
      write_data    <= '0;
      write_address <= '0;
      write_enable  <= 1'b0;
    end else begin
      div_cnt      <= div_next;
      mic_clk      <= (div_next < DIV_W'(MIC_DIV / 2));
      write_enable <= 1'b0;
      if (start_capture) begin
        bit_index     <= '0;
        write_address <= '0;
      end else begin
        if (write_enable) write_address <= write_address + ADDR_WIDTH'(1);
        if (capture) begin
          shreg     <= shreg_next;
          bit_index <= bit_index + BW'(1);
          if (bit_index == BW'(MEM_WIDTH - 1)) begin
            write_enable <= 1'b1;
            write_data   <= shreg_next;
          end
        end
      end
    end
  end

endmodule
